tt_decoded_mux_pipe: RTL and testbench
======================================

Name: tt_decoded_mux_pipe

Overview:
- Parametrised, pipelined one-hot-select mux for RVV datapath operand steering.
- Carries a valid/ready stream through PIPE_DEPTH registered stages.
- Checks select legality in hardware: no sim-only assertion; reports zero-hot and multi-hot selects as a per-beat error bit, a sticky flag and a saturating counter.
- Sits between the operand read ports and the VEX lane input queues; fully replaces the purely combinational decoded mux where timing needs a register.

Parameters:
- VALUE_WIDTH, 32, width of each data input and of the output.
- MUX_WIDTH, 4, number of inputs; legal range 2..32.
- PIPE_DEPTH, 1, number of registered stages; legal range 1..4.
- SEL_MODE, 0, multi-hot resolution: 0 = OR-merge all selected inputs, 1 = lowest selected index wins.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_inputs  in  [VALUE_WIDTH-1:0] x MUX_WIDTH  candidate values
- i_select  in  MUX_WIDTH  decoded select, expected one-hot
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the beat
- o_output  out  VALUE_WIDTH  selected value
- o_sel_err  out  1  the current output beat had an illegal select
- o_err_sticky  out  1  an illegal select has been accepted since the last clear
- o_err_cnt  out  ERR_CNT_WIDTH  saturating count of accepted illegal beats
- i_err_clr  in  1  clears o_err_sticky and o_err_cnt

Behaviour:
- Input transfer occurs when i_valid && o_ready. Output transfer occurs when o_valid && i_ready. i_inputs/i_select are sampled only on an input transfer.
- Combinational select, applied before stage 0:
  - zero-hot: data = 0, err = 1.
  - one-hot: data = the selected input, err = 0.
  - multi-hot, SEL_MODE=0: data = OR of all selected inputs, err = 1.
  - multi-hot, SEL_MODE=1: data = lowest-index selected input, err = 1.
- Pipeline: stages S0..S(PIPE_DEPTH-1). Each stage holds {vld, data, err}.
  - Stage k loads when it is empty, or when stage k+1 (or the output, for the last stage) takes its beat in the same cycle.
  - o_ready = S0 loadable. It depends on i_ready combinationally through the chain; no extra skid stage.
  - o_valid / o_output / o_sel_err are driven directly from the last stage's registers.
- Latency: an accepted beat appears on o_valid exactly PIPE_DEPTH cycles later if the path is unstalled. Throughput is 1 beat/cycle at full occupancy.
- Stall: with i_ready=0, the pipe fills to PIPE_DEPTH beats, then o_ready drops. Output data is held stable while o_valid && !i_ready.
- Beats leave in order. No beat is dropped or duplicated.
- Error tracking uses input-side accounting: an illegal beat counts at input acceptance, not at output.
  - o_err_sticky is set on an input transfer with err=1.
  - o_err_cnt increments on each such transfer and saturates at all-ones; it never wraps.
  - i_err_clr alone: sticky=0, cnt=0 next cycle.
  - i_err_clr in the same cycle as an accepted illegal beat: sticky=1, cnt=1 (the set wins, counting from zero).
- Reset, applied at any time including mid-stream: all stage vld=0, data=0, err=0, sticky=0, cnt=0, so o_valid=0, o_output=0, o_sel_err=0.
  - o_ready=1 in the first cycle after reset deasserts. o_ready is forced 0 while i_reset=1.
  - Beats in flight are discarded.
- i_valid=0 with garbage on i_select has no effect on the error state.

Decomposition:
- Package tt_decoded_mux_pkg holds:
  - the sel_mode_e enum (SEL_OR=0, SEL_LOWEST=1);
  - the stage struct {vld, data, err}, parametrised by width in the module;
  - the localparams PIPE_DEPTH_MAX=4 and MUX_WIDTH_MAX=32.
- One sub-module, tt_onehot_sel_core: purely combinational. Takes inputs and select and produces data and err for the chosen SEL_MODE. It is reused by the lane crossbar.
- The pipeline stages are a generate loop in the top module.

Test Plan:
- MUX_WIDTH=4, PIPE_DEPTH=2, i_ready=1: drive inputs {0x11,0x22,0x33,0x44} and select 4'b0100 for one beat. The beat is accepted, o_valid is seen 2 cycles later with o_output=0x33 and o_sel_err=0, and the sticky flag stays 0.
- Select 4'b0000 -> o_output=0, o_sel_err=1, o_err_sticky=1, o_err_cnt=1.
- Select 4'b0110, SEL_MODE=0 -> o_output=0x22|0x33=0x33 with o_sel_err=1. SEL_MODE=1 -> o_output=0x22 with o_sel_err=1.
- PIPE_DEPTH=3, i_ready=0, i_valid held high with 5 beats queued:
  - exactly 3 beats are accepted, then o_ready=0;
  - after i_ready rises, beats 0,1,2 emerge in order on consecutive cycles, then beats 3,4 follow;
  - o_output stays stable while stalled.
- ERR_CNT_WIDTH=2:
  - 5 illegal beats -> o_err_cnt=3 (saturated);
  - i_err_clr together with a 6th illegal beat -> next cycle sticky=1, cnt=1.
- Assert i_reset for 1 cycle with 2 beats in flight -> o_valid=0 and o_output=0 next cycle; the discarded beats never appear, and o_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/tt_decoded_mux_pkg.sv
// tt_decoded_mux_pkg: shared types and limits for the decoded-mux family
package tt_decoded_mux_pkg;
  typedef enum logic {SEL_OR = 1'b0, SEL_LOWEST = 1'b1} sel_mode_e;
  localparam int PIPE_DEPTH_MAX = 4;
  localparam int MUX_WIDTH_MAX = 32;
  function automatic logic is_onehot(input logic [MUX_WIDTH_MAX-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/tt_onehot_sel_core.sv
// tt_onehot_sel_core: combinational one-hot select with legality flag
module tt_onehot_sel_core
  import tt_decoded_mux_pkg::*;
#(
  parameter int VALUE_WIDTH = 32,
  parameter int MUX_WIDTH   = 4,
  parameter int SEL_MODE    = 0
) (
  input  logic [MUX_WIDTH-1:0][VALUE_WIDTH-1:0] inputs_i,
  input  logic [MUX_WIDTH-1:0]                  select_i,
  output logic [VALUE_WIDTH-1:0]                data_o,
  output logic                                  err_o
);
  logic [VALUE_WIDTH-1:0] or_data, low_data;
  logic found;
  always_comb begin
    or_data  = '0;
    low_data = '0;
    found    = 1'b0;
    for (int i = 0; i < MUX_WIDTH; i++) begin
      or_data |= select_i[i] ? inputs_i[i] : '0;
      low_data = (select_i[i] && !found) ? inputs_i[i] : low_data;
      found    = found || select_i[i];
    end
  end
  assign data_o = (SEL_MODE == int'(SEL_LOWEST)) ? low_data : or_data;
  assign err_o  = !is_onehot(MUX_WIDTH_MAX'(select_i));
endmodule

// File: rtl/tt_decoded_mux_pipe.sv
// tt_decoded_mux_pipe: pipelined one-hot mux with valid/ready and select error tracking
module tt_decoded_mux_pipe
  import tt_decoded_mux_pkg::*;
#(
  parameter int VALUE_WIDTH   = 32,
  parameter int MUX_WIDTH     = 4,
  parameter int PIPE_DEPTH    = 1,
  parameter int SEL_MODE      = 0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [MUX_WIDTH-1:0][VALUE_WIDTH-1:0] i_inputs,
  input  logic [MUX_WIDTH-1:0]                  i_select,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [VALUE_WIDTH-1:0]                o_output,
  output logic                                  o_sel_err,
  output logic                                  o_err_sticky,
  output logic [ERR_CNT_WIDTH-1:0]              o_err_cnt,
  input  logic                                  i_err_clr
);
  typedef struct packed {
    logic                   vld;
    logic [VALUE_WIDTH-1:0] data;
    logic                   err;
  } stage_t;
  stage_t s_q [PIPE_DEPTH];
  stage_t in_stage;
  logic [VALUE_WIDTH-1:0] sel_data;
  logic sel_err, in_xfer, err_set, sticky_q, sticky_d;
  logic [PIPE_DEPTH-1:0] vld;
  logic [PIPE_DEPTH:0] ld;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  tt_onehot_sel_core #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .MUX_WIDTH  (MUX_WIDTH),
    .SEL_MODE   (SEL_MODE)
  ) u_core (
    .inputs_i(i_inputs),
    .select_i(i_select),
    .data_o  (sel_data),
    .err_o   (sel_err)
  );
  // ready ripples back from the output: a stage frees up when its successor takes its beat
  always_comb begin
    ld[PIPE_DEPTH] = i_ready;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) ld[i] = !vld[i] || ld[i+1];
  end
  assign o_ready  = ld[0] && !i_reset;
  assign in_xfer  = i_valid && o_ready;
  assign in_stage = in_xfer ? {1'b1, sel_data, sel_err} : '0;
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    stage_t src;
    if (k == 0) begin : g_head
      assign src = in_stage;
    end else begin : g_body
      assign src = s_q[k-1];
    end
    assign vld[k] = s_q[k].vld;
    always_ff @(posedge i_clk) begin
      if (i_reset) s_q[k] <= '0;
      else if (ld[k]) s_q[k] <= src;
    end
  end
  assign o_valid   = s_q[PIPE_DEPTH-1].vld;
  assign o_output  = s_q[PIPE_DEPTH-1].data;
  assign o_sel_err = s_q[PIPE_DEPTH-1].err;
  // a clear coinciding with an illegal beat restarts the count at one
  assign err_set  = in_xfer && sel_err;
  assign sticky_d = err_set || (sticky_q && !i_err_clr);
  assign cnt_d    = i_err_clr ? {{(ERR_CNT_WIDTH-1){1'b0}}, err_set}
                  : (err_set && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
  assign o_err_sticky = sticky_q;
  assign o_err_cnt    = cnt_q;
endmodule

// File: tb/tb_tt_decoded_mux_pipe.sv
// tb_tt_decoded_mux_pipe: directed checks on an OR-mode depth-2 and a lowest-mode depth-3 instance
module tb_tt_decoded_mux_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             valid_a = 1'b0, ready_a = 1'b1, clr_a = 1'b0;
  logic [3:0][31:0] inputs_a;
  logic [3:0]       sel_a = '0;
  logic             ordy_a, ov_a, serr_a, sticky_a;
  logic [31:0]      out_a;
  logic [1:0]       cnt_a;

  logic             valid_b = 1'b0, ready_b = 1'b1, clr_b = 1'b0;
  logic [3:0][31:0] inputs_b;
  logic [3:0]       sel_b = '0;
  logic             ordy_b, ov_b, serr_b, sticky_b;
  logic [31:0]      out_b;
  logic [7:0]       cnt_b;

  int n_vec = 0;
  int n_bad = 0;

  tt_decoded_mux_pipe #(
    .VALUE_WIDTH(32), .MUX_WIDTH(4), .PIPE_DEPTH(2), .SEL_MODE(0), .ERR_CNT_WIDTH(2)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .i_valid(valid_a), .o_ready(ordy_a),
    .i_inputs(inputs_a), .i_select(sel_a), .o_valid(ov_a), .i_ready(ready_a),
    .o_output(out_a), .o_sel_err(serr_a), .o_err_sticky(sticky_a),
    .o_err_cnt(cnt_a), .i_err_clr(clr_a)
  );

  tt_decoded_mux_pipe #(
    .VALUE_WIDTH(32), .MUX_WIDTH(4), .PIPE_DEPTH(3), .SEL_MODE(1), .ERR_CNT_WIDTH(8)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .i_valid(valid_b), .o_ready(ordy_b),
    .i_inputs(inputs_b), .i_select(sel_b), .o_valid(ov_b), .i_ready(ready_b),
    .o_output(out_b), .o_sel_err(serr_b), .o_err_sticky(sticky_b),
    .o_err_cnt(cnt_b), .i_err_clr(clr_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [3:0] sel);
    valid_a = 1'b1;
    sel_a   = sel;
    tick();
    valid_a = 1'b0;
  endtask

  task automatic beat_b(input logic [3:0] sel);
    valid_b = 1'b1;
    sel_b   = sel;
    tick();
    valid_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int nacc, ng, nv;
    logic [31:0] got [5];
    int at [5];
    inputs_a = {32'h44, 32'h33, 32'h22, 32'h11};
    inputs_b = {32'h44, 32'h33, 32'h22, 32'h11};
    tick();
    tick();
    chk("rst_rdy_a", ordy_a, 1'b0);
    chk("rst_ov_a", ov_a, 1'b0);
    chk("rst_out_a", out_a, 32'h0);
    chk("rst_cnt_a", cnt_a, 2'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy_a", ordy_a, 1'b1);
    chk("post_rst_rdy_b", ordy_b, 1'b1);

    beat_a(4'b0100);
    chk("lat_early_ov", ov_a, 1'b0);
    tick();
    chk("onehot_ov", ov_a, 1'b1);
    chk("onehot_out", out_a, 32'h33);
    chk("onehot_err", serr_a, 1'b0);
    chk("onehot_sticky", sticky_a, 1'b0);

    beat_a(4'b0000);
    chk("zero_sticky", sticky_a, 1'b1);
    chk("zero_cnt", cnt_a, 2'd1);
    tick();
    chk("zero_out", out_a, 32'h0);
    chk("zero_err", serr_a, 1'b1);

    beat_a(4'b0110);
    chk("or_cnt", cnt_a, 2'd2);
    tick();
    chk("or_out", out_a, 32'h33);
    chk("or_err", serr_a, 1'b1);

    beat_b(4'b0110);
    chk("low_sticky", sticky_b, 1'b1);
    chk("low_cnt", cnt_b, 8'd1);
    tick();
    tick();
    chk("low_ov", ov_b, 1'b1);
    chk("low_out", out_b, 32'h22);
    chk("low_err", serr_b, 1'b1);

    valid_a = 1'b1;
    sel_a   = 4'b0000;
    tick();
    tick();
    tick();
    chk("sat_cnt", cnt_a, 2'd3);
    clr_a = 1'b1;
    tick();
    chk("clr_set_sticky", sticky_a, 1'b1);
    chk("clr_set_cnt", cnt_a, 2'd1);
    valid_a = 1'b0;
    tick();
    chk("clr_sticky", sticky_a, 1'b0);
    chk("clr_cnt", cnt_a, 2'd0);
    clr_a = 1'b0;
    sel_a = 4'b1111;
    tick();
    tick();
    chk("idle_garbage_cnt", cnt_a, 2'd0);
    chk("idle_garbage_sticky", sticky_a, 1'b0);

    for (int c = 0; c < 4; c++) tick();
    ready_b = 1'b0;
    valid_b = 1'b1;
    sel_b   = 4'b0001;
    nacc    = 0;
    for (int c = 0; c < 6; c++) begin
      inputs_b[0] = 32'hA0 + 32'(nacc);
      #1;
      if (ordy_b) nacc++;
      tick();
    end
    chk("stall_accepted", nacc, 3);
    chk("stall_rdy", ordy_b, 1'b0);
    chk("stall_ov", ov_b, 1'b1);
    chk("stall_out", out_b, 32'hA0);
    tick();
    chk("stall_hold", out_b, 32'hA0);

    ready_b = 1'b1;
    ng = 0;
    for (int c = 0; c < 12 && ng < 5; c++) begin
      inputs_b[0] = 32'hA0 + 32'(nacc);
      valid_b = (nacc < 5);
      #1;
      if (valid_b && ordy_b) nacc++;
      if (ov_b) begin
        got[ng] = out_b;
        at[ng]  = c;
        ng++;
      end
      tick();
    end
    valid_b = 1'b0;
    chk("drain_count", ng, 5);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("drain_data%0d", k), got[k], 32'hA0 + 32'(k));
      chk($sformatf("drain_cycle%0d", k), at[k], k);
    end

    for (int c = 0; c < 4; c++) tick();
    valid_a = 1'b1;
    sel_a   = 4'b0011;
    tick();
    tick();
    valid_a = 1'b0;
    chk("pre_rst_sticky", sticky_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("in_rst_rdy", ordy_a, 1'b0);
    tick();
    chk("mid_rst_ov", ov_a, 1'b0);
    chk("mid_rst_out", out_a, 32'h0);
    chk("mid_rst_err", serr_a, 1'b0);
    chk("mid_rst_sticky", sticky_a, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_post_rdy", ordy_a, 1'b1);
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ov_a) nv++;
    end
    chk("discarded_beats", nv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
